guess_scorer: RTL and testbench



---
 rtl/guess_scorer.sv | 184 ++++++++++++++++++
 tb/tb_guess_scorer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/guess_scorer.sv
// Guess scorer: draws an N-slot secret, scores handshaked guesses with duplicate-aware hints.
// Optional macro GUESS_SCORER_FIXED_SECRET_EN adds SECRET_IN and loads the secret from it.
module guess_scorer #(
    parameter int unsigned SLOTS     = 3,
    parameter int unsigned SYM_W     = 3,
    parameter int unsigned MAX_TRIES = 6,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     NEW_GAME,
    input  logic                     GUESS_VALID,
    output logic                     GUESS_READY,
    input  logic [SLOTS*SYM_W-1:0]   GUESS,
`ifdef GUESS_SCORER_FIXED_SECRET_EN
    input  logic [SLOTS*SYM_W-1:0]   SECRET_IN,
`endif
    output logic                     HINT_VALID,
    output logic [2*SLOTS-1:0]       HINTS,
    output logic [7:0]               TRIES,
    output logic                     WIN,
    output logic                     LOSE,
    output logic                     BUSY
);

    localparam int unsigned GW = SLOTS * SYM_W;
    localparam int unsigned CW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [CW-1:0] LAST = CW'(SLOTS - 1);

    typedef enum logic [2:0] {
        StIdle, StDraw, StWait, StExact, StPresent, StReport, StDone
    } state_e;

    state_e             state_q;
    logic [15:0]        lfsr_q;
    logic [GW-1:0]      secret_q;
    logic [GW-1:0]      guess_q;
    logic [SLOTS-1:0]   exact_q;
    logic [SLOTS-1:0]   consumed_q;
    logic [2*SLOTS-1:0] scored_q;
    logic [CW-1:0]      cnt_q;
    logic [2*SLOTS-1:0] hints_q;
    logic               hint_valid_q;
    logic [7:0]         tries_q;
    logic               win_q;
    logic               lose_q;

    logic [15:0]        lfsr_step;
    logic [15:0]        guess16;
    logic [SYM_W-1:0]   draw_sym;
    logic [SLOTS-1:0]   exact_vec;
    logic [SYM_W-1:0]   cur_sym;
    logic               found;
    logic [SLOTS-1:0]   consumed_nxt;
    logic [1:0]         hint_cur;
    logic [2*SLOTS-1:0] scored_nxt;

    // Galois form of x^16+x^14+x^13+x^11+1
    assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    generate
        if (GW >= 16) begin : g_guess_trunc
            assign guess16 = GUESS[15:0];
        end else begin : g_guess_ext
            assign guess16 = {{(16 - GW){1'b0}}, GUESS};
        end
    endgenerate

`ifdef GUESS_SCORER_FIXED_SECRET_EN
    assign draw_sym = SECRET_IN[cnt_q*SYM_W +: SYM_W];
`else
    assign draw_sym = lfsr_q[SYM_W-1:0];
`endif

    always_comb begin
        exact_vec = '0;
        for (int i = 0; i < SLOTS; i++) begin
            exact_vec[i] = (guess_q[i*SYM_W +: SYM_W] == secret_q[i*SYM_W +: SYM_W]);
        end
    end

    // One guess slot per cycle; the lowest unconsumed matching secret slot is claimed.
    always_comb begin
        cur_sym      = guess_q[cnt_q*SYM_W +: SYM_W];
        found        = 1'b0;
        consumed_nxt = consumed_q;
        if (!exact_q[cnt_q]) begin
            for (int j = 0; j < SLOTS; j++) begin
                if (!found && !consumed_q[j] && (secret_q[j*SYM_W +: SYM_W] == cur_sym)) begin
                    found           = 1'b1;
                    consumed_nxt[j] = 1'b1;
                end
            end
        end
        hint_cur   = exact_q[cnt_q] ? 2'b01 : (found ? 2'b10 : 2'b00);
        scored_nxt = scored_q;
        scored_nxt[cnt_q*2 +: 2] = hint_cur;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StIdle;
            lfsr_q       <= SEED;
            secret_q     <= '0;
            guess_q      <= '0;
            exact_q      <= '0;
            consumed_q   <= '0;
            scored_q     <= '0;
            cnt_q        <= '0;
            hints_q      <= '0;
            hint_valid_q <= 1'b0;
            tries_q      <= '0;
            win_q        <= 1'b0;
            lose_q       <= 1'b0;
        end else begin
            lfsr_q       <= lfsr_step;
            hint_valid_q <= 1'b0;
            if (NEW_GAME) begin
                state_q    <= StDraw;
                cnt_q      <= '0;
                tries_q    <= '0;
                win_q      <= 1'b0;
                lose_q     <= 1'b0;
                hints_q    <= '0;
                exact_q    <= '0;
                consumed_q <= '0;
                scored_q   <= '0;
            end else begin
                case (state_q)
                    StDraw: begin
                        secret_q[cnt_q*SYM_W +: SYM_W] <= draw_sym;
                        if (cnt_q == LAST) begin
                            cnt_q   <= '0;
                            state_q <= StWait;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StWait: begin
                        if (GUESS_VALID) begin
                            guess_q <= GUESS;
                            lfsr_q  <= lfsr_step ^ guess16;
                            state_q <= StExact;
                        end
                    end
                    StExact: begin
                        exact_q    <= exact_vec;
                        consumed_q <= exact_vec;
                        scored_q   <= '0;
                        cnt_q      <= '0;
                        state_q    <= StPresent;
                    end
                    StPresent: begin
                        consumed_q <= consumed_nxt;
                        scored_q   <= scored_nxt;
                        if (cnt_q == LAST) begin
                            // Results land with the pulse so HINTS is valid while HINT_VALID is high.
                            hints_q      <= scored_nxt;
                            hint_valid_q <= 1'b1;
                            tries_q      <= tries_q + 8'd1;
                            win_q        <= &exact_q;
                            lose_q       <= !(&exact_q) && (tries_q + 8'd1 == 8'(MAX_TRIES));
                            cnt_q        <= '0;
                            state_q      <= StReport;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StReport: state_q <= (win_q || lose_q) ? StDone : StWait;
                    default: ;
                endcase
            end
        end
    end

    assign GUESS_READY = (state_q == StWait);
    assign BUSY        = (state_q == StDraw) || (state_q == StExact) || (state_q == StPresent);
    assign HINT_VALID  = hint_valid_q;
    assign HINTS       = hints_q;
    assign TRIES       = tries_q;
    assign WIN         = win_q;
    assign LOSE        = lose_q;

endmodule

// File: tb/tb_guess_scorer.sv
// Self-checking bench for guess_scorer: vector table plus scoreboard of expected reports.
module tb_guess_scorer;

    localparam int SLOTS     = 3;
    localparam int SYM_W     = 3;
    localparam int MAX_TRIES = 6;
    localparam int GW        = SLOTS * SYM_W;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [2*SLOTS-1:0] ALL_EXACT = {SLOTS{2'b01}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic new_game = 1'b0;
    logic guess_valid = 1'b0;
    logic [GW-1:0] guess = '0;
`ifdef GUESS_SCORER_FIXED_SECRET_EN
    logic [GW-1:0] secret_in = '0;
`endif
    logic guess_ready, hint_valid, win, lose, busy;
    logic [2*SLOTS-1:0] hints;
    logic [7:0] tries;

    always #5 clk = ~clk;

    guess_scorer #(
        .SLOTS(SLOTS), .SYM_W(SYM_W), .MAX_TRIES(MAX_TRIES), .SEED(SEED)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .NEW_GAME(new_game),
        .GUESS_VALID(guess_valid),
        .GUESS_READY(guess_ready),
        .GUESS(guess),
`ifdef GUESS_SCORER_FIXED_SECRET_EN
        .SECRET_IN(secret_in),
`endif
        .HINT_VALID(hint_valid),
        .HINTS(hints),
        .TRIES(tries),
        .WIN(win),
        .LOSE(lose),
        .BUSY(busy)
    );

    typedef struct {
        logic [2*SLOTS-1:0] hints;
        logic               win;
        logic               lose;
        logic [7:0]         tries;
        int                 cyc;
    } exp_t;

    typedef struct {
        logic [GW-1:0]      sec;
        logic [GW-1:0]      g;
        bit                 self_g;
        logic [2*SLOTS-1:0] hints;
        bit                 win;
    } vec_t;

    exp_t expq[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int hv_count = 0;
    int acc_count = 0;
    int exp_tries = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [GW-1:0] pk(input int a0, input int a1, input int a2);
        return {3'(a2), 3'(a1), 3'(a0)};
    endfunction

    function automatic logic [15:0] lstep(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [2*SLOTS-1:0] ref_score(input logic [GW-1:0] sec,
                                                     input logic [GW-1:0] g);
        logic [SLOTS-1:0] used;
        logic [2*SLOTS-1:0] h;
        h = '0;
        for (int i = 0; i < SLOTS; i++) used[i] = (sec[i*SYM_W +: SYM_W] == g[i*SYM_W +: SYM_W]);
        for (int i = 0; i < SLOTS; i++) begin
            if (sec[i*SYM_W +: SYM_W] == g[i*SYM_W +: SYM_W]) begin
                h[2*i +: 2] = 2'b01;
            end else begin
                for (int j = 0; j < SLOTS; j++) begin
                    if (!used[j] && sec[j*SYM_W +: SYM_W] == g[i*SYM_W +: SYM_W]) begin
                        used[j] = 1'b1;
                        h[2*i +: 2] = 2'b10;
                        break;
                    end
                end
            end
        end
        return h;
    endfunction

`ifndef GUESS_SCORER_FIXED_SECRET_EN
    logic [15:0] mdl_lfsr = SEED;
    logic [GW-1:0] mdl_secret = '0;
    int mdl_draw = SLOTS;

    always @(posedge clk) begin
        if (rst) begin
            mdl_lfsr   <= SEED;
            mdl_secret <= '0;
            mdl_draw   <= SLOTS;
        end else begin
            mdl_lfsr <= lstep(mdl_lfsr) ^
                        ((guess_valid && guess_ready && !new_game) ? 16'(guess) : 16'h0000);
            if (new_game) begin
                mdl_draw <= 0;
            end else if (mdl_draw < SLOTS) begin
                mdl_secret[mdl_draw*SYM_W +: SYM_W] <= mdl_lfsr[SYM_W-1:0];
                mdl_draw <= mdl_draw + 1;
            end
        end
    end
`endif

    function automatic logic [GW-1:0] cur_secret();
`ifdef GUESS_SCORER_FIXED_SECRET_EN
        return secret_in;
`else
        return mdl_secret;
`endif
    endfunction

    function automatic exp_t make_exp(input logic [GW-1:0] sec, input logic [GW-1:0] g,
                                      input int t, input int c);
        exp_t e;
        e.hints = ref_score(sec, g);
        e.win   = (e.hints == ALL_EXACT);
        e.tries = 8'(t);
        e.lose  = !e.win && (t == MAX_TRIES);
        e.cyc   = c;
        return e;
    endfunction

    // Scoreboard producer: every handshake pushes the report it must eventually cause.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst || new_game) begin
            exp_tries <= 0;
            expq.delete();
        end else if (guess_valid && guess_ready) begin
            expq.push_back(make_exp(cur_secret(), guess, exp_tries + 1, cyc));
            exp_tries <= exp_tries + 1;
            acc_count <= acc_count + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst && hint_valid) begin
            hv_count <= hv_count + 1;
            check("hv_expected", 64'(expq.size() != 0), 1);
            if (expq.size() != 0) begin
                check("hv_hints", hints, expq[0].hints);
                check("hv_win", win, expq[0].win);
                check("hv_lose", lose, expq[0].lose);
                check("hv_tries", tries, expq[0].tries);
                check("hv_latency", cyc - expq[0].cyc, SLOTS + 2);
                void'(expq.pop_front());
            end
        end
    end

    task automatic wait_ready();
        int k = 0;
        while (!guess_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("ready_wait", guess_ready, 1);
    endtask

    task automatic start_game(input logic [GW-1:0] sec);
        int m;
`ifdef GUESS_SCORER_FIXED_SECRET_EN
        secret_in = sec;
`endif
        new_game = 1'b1;
        m = cyc;
        @(negedge clk);
        new_game = 1'b0;
        check("draw_busy", busy, 1);
        wait_ready();
        check("ready_after_new_game", cyc - m, SLOTS + 1);
    endtask

    task automatic do_guess(input logic [GW-1:0] g);
        guess = g;
        guess_valid = 1'b1;
        wait_ready();
        @(negedge clk);
        guess_valid = 1'b0;
    endtask

    task automatic wait_hv();
        int k = 0;
        while (expq.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("hv_arrived", expq.size(), 0);
        @(negedge clk);
    endtask

    vec_t tab[6];

    initial begin
        int hv0;
        int a0;
        logic [GW-1:0] g;
        bit w;

        tab[0] = '{pk(5, 2, 7), pk(5, 2, 7), 1'b1, 6'b010101, 1'b1};
        tab[1] = '{pk(3, 3, 1), pk(3, 1, 3), 1'b0, 6'b101001, 1'b0};
        tab[2] = '{pk(1, 2, 2), pk(2, 2, 2), 1'b0, 6'b010100, 1'b0};
        tab[3] = '{pk(4, 4, 4), pk(4, 0, 0), 1'b0, 6'b000001, 1'b0};
        tab[4] = '{pk(6, 1, 0), pk(0, 6, 1), 1'b0, 6'b101010, 1'b0};
        tab[5] = '{pk(2, 5, 2), pk(2, 2, 2), 1'b0, 6'b010001, 1'b0};

        repeat (2) @(negedge clk);
        check("reset_outputs", {guess_ready, hint_valid, hints, tries, win, lose, busy}, 0);
        rst = 1'b0;

        guess_valid = 1'b1;
        guess = pk(1, 2, 3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_ready", guess_ready, 0);
        end
        check("idle_tries", tries, 0);
        check("idle_busy", busy, 0);
        guess_valid = 1'b0;

        for (int i = 0; i < 6; i++) begin
            start_game(tab[i].sec);
            g = tab[i].self_g ? cur_secret() : tab[i].g;
            w = (ref_score(cur_secret(), g) == ALL_EXACT);
            do_guess(g);
            wait_hv();
`ifdef GUESS_SCORER_FIXED_SECRET_EN
            check($sformatf("tab%0d_hints", i), hints, tab[i].hints);
            check($sformatf("tab%0d_win", i), win, tab[i].win);
`endif
            check($sformatf("tab%0d_ready_after", i), guess_ready, !w);
            check($sformatf("tab%0d_win_hold", i), win, w);
        end

        // Loss: every guess misses every slot exactly.
        start_game(pk(0, 0, 0));
        for (int i = 0; i < MAX_TRIES; i++) begin
            do_guess(~cur_secret());
            wait_hv();
            check("loss_ready", guess_ready, i < MAX_TRIES - 1);
`ifdef GUESS_SCORER_FIXED_SECRET_EN
            check("loss_hints", hints, 0);
`endif
        end
        repeat (3) @(negedge clk);
        check("loss_hold_lose", lose, 1);
        check("loss_done_ready", guess_ready, 0);
        check("loss_tries", tries, MAX_TRIES);

        // Abort: NEW_GAME lands on the second PRESENT cycle.
        start_game(pk(1, 2, 3));
        do_guess(~cur_secret());
        wait_hv();
        check("abort_pre_tries", tries, 1);
        hv0 = hv_count;
        guess = ~cur_secret();
        guess_valid = 1'b1;
        wait_ready();
        @(negedge clk);
        guess_valid = 1'b0;
        repeat (2) @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        check("abort_busy", busy, 1);
        check("abort_tries", tries, 0);
        check("abort_win", win, 0);
        check("abort_hints", hints, 0);
        repeat (SLOTS + 2) @(negedge clk);
        check("abort_no_hv", hv_count, hv0);
        check("abort_redraw_ready", guess_ready, 1);

        // Back-pressure: VALID held high through scoring.
        start_game(pk(1, 2, 3));
        a0 = acc_count;
        guess = ~cur_secret();
        guess_valid = 1'b1;
        wait_ready();
        for (int i = 1; i <= SLOTS + 2; i++) begin
            @(negedge clk);
            check("bp_ready_low", guess_ready, 0);
        end
        check("bp_one_accept", acc_count - a0, 1);
        @(negedge clk);
        check("bp_ready_again", guess_ready, 1);
        @(negedge clk);
        guess_valid = 1'b0;
        check("bp_two_accepts", acc_count - a0, 2);
        wait_hv();
        check("bp_tries", tries, 2);

        // Reset while in EXACT.
        guess = ~cur_secret();
        guess_valid = 1'b1;
        wait_ready();
        @(negedge clk);
        guess_valid = 1'b0;
        check("mid_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_outputs", {guess_ready, hint_valid, hints, tries, win, lose, busy}, 0);
        rst = 1'b0;
        hv0 = hv_count;
        guess_valid = 1'b1;
        for (int i = 0; i < SLOTS + 3; i++) begin
            @(negedge clk);
            check("rst_idle_ready", guess_ready, 0);
        end
        guess_valid = 1'b0;
        check("rst_no_hv", hv_count, hv0);
        check("rst_tries", tries, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
